// File: rtl/fp16_add_arbiter.sv
// Round-robin scheduler sharing one pipelined fp16 adder among N_REQ requesters, routing tagged results back.
// Define FP16_ARB_STAT_EN to add per-requester NaN/inf result counters (STAT_EXC, STAT_CLR).
module fp16_add_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADD_LAT   = 3,
  parameter int MAX_OUTST = 4
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                EN,
  input  logic [N_REQ-1:0]    REQ_VALID,
  input  logic [16*N_REQ-1:0] REQ_A,
  input  logic [16*N_REQ-1:0] REQ_B,
  output logic [N_REQ-1:0]    REQ_READY,
  output logic                ADD_DVI,
  output logic [15:0]         ADD_A,
  output logic [15:0]         ADD_B,
  input  logic [15:0]         ADD_DO,
  input  logic [5:0]          ADD_DO_TYPE,
  output logic [N_REQ-1:0]    RSP_VALID,
  output logic [15:0]         RSP_DATA,
  output logic [5:0]          RSP_TYPE,
`ifdef FP16_ARB_STAT_EN
  input  logic                STAT_CLR,
  output logic [16*N_REQ-1:0] STAT_EXC,
`endif
  output logic                IDLE
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  id_t              ptr;
  id_t              issue_id;
  id_t              grant_id;
  logic             grant_any;
  logic [N_REQ-1:0] eligible;
  logic [15:0]      sel_a;
  logic [15:0]      sel_b;
  cnt_t             outst     [N_REQ];
  cnt_t             outst_nxt [N_REQ];
  tag_t             tags      [ADD_LAT+1];
  tag_t             aligned;
  logic             idle_nxt;

  // Stage 0 captures the tag as DVI enters the adder; the last stage lines up with ADD_DO.
  assign aligned = tags[ADD_LAT];

  // Two passes give the wrap-around search: indices at/after ptr first, then those before it.
  // NOTE: every always_comb output gets a default before any branch so no path can infer a latch.
  always_comb begin
    REQ_READY = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    eligible  = '0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = REQ_VALID[i] && (outst[i] < MAX_CNT);
    if (EN && RSTn) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!grant_any && eligible[i] &&
              ((pass == 0) ? (i >= int'(ptr)) : (i < int'(ptr)))) begin
            grant_any    = 1'b1;
            grant_id     = id_t'(i);
            REQ_READY[i] = 1'b1;
            sel_a        = REQ_A[16*i +: 16];
            sel_b        = REQ_B[16*i +: 16];
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ADD_DVI  <= 1'b0;
      ADD_A    <= '0;
      ADD_B    <= '0;
      issue_id <= '0;
      ptr      <= '0;
    end else begin
      ADD_DVI <= grant_any;
      if (grant_any) begin
        ADD_A    <= sel_a;
        ADD_B    <= sel_b;
        issue_id <= grant_id;
        ptr      <= (grant_id == id_t'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // NOTE: the tag array is reset on purpose; clearing it is what drops in-flight results on reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k <= ADD_LAT; k++) tags[k] <= '0;
    end else begin
      tags[0] <= '{vld: ADD_DVI, id: issue_id};
      for (int k = 1; k <= ADD_LAT; k++) tags[k] <= tags[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      RSP_VALID <= '0;
      RSP_DATA  <= '0;
      RSP_TYPE  <= '0;
    end else begin
      RSP_VALID <= '0;
      if (aligned.vld) begin
        for (int i = 0; i < N_REQ; i++)
          if (aligned.id == id_t'(i)) RSP_VALID[i] <= 1'b1;
        RSP_DATA <= ADD_DO;
        RSP_TYPE <= ADD_DO_TYPE;
      end
    end
  end

  // A slot is returned on the edge after its response strobe, so READY reopens one cycle later.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      outst_nxt[i] = outst[i];
      if (REQ_READY[i] && !RSP_VALID[i])
        outst_nxt[i] = outst[i] + 1'b1;
      else if (!REQ_READY[i] && RSP_VALID[i])
        outst_nxt[i] = outst[i] - 1'b1;
    end
  end

  // IDLE is registered from next-state values so it rises right after the final drain edge.
  always_comb begin
    idle_nxt = !grant_any && !ADD_DVI;
    for (int k = 0; k <= ADD_LAT; k++)
      if (tags[k].vld) idle_nxt = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (outst_nxt[i] != '0) idle_nxt = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N_REQ; i++) outst[i] <= '0;
      IDLE <= 1'b1;
    end else begin
      for (int i = 0; i < N_REQ; i++) outst[i] <= outst_nxt[i];
      IDLE <= idle_nxt;
    end
  end

`ifdef FP16_ARB_STAT_EN
  logic [15:0] exc_cnt [N_REQ];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N_REQ; i++) exc_cnt[i] <= '0;
    end else if (STAT_CLR) begin
      for (int i = 0; i < N_REQ; i++) exc_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (RSP_VALID[i] && (RSP_TYPE[2:0] != 3'b000) && (exc_cnt[i] != 16'hFFFF))
          exc_cnt[i] <= exc_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    STAT_EXC = '0;
    for (int i = 0; i < N_REQ; i++) STAT_EXC[16*i +: 16] = exc_cnt[i];
  end
`endif

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter with a mock pipelined adder; covers the stat counters when FP16_ARB_STAT_EN is defined.
module tb_fp16_add_arbiter;

  localparam int N_REQ     = 4;
  localparam int ADD_LAT   = 3;
  localparam int MAX_OUTST = 4;

  logic                CLK;
  logic                RSTn;
  logic                EN;
  logic [N_REQ-1:0]    REQ_VALID;
  logic [16*N_REQ-1:0] REQ_A;
  logic [16*N_REQ-1:0] REQ_B;
  logic [N_REQ-1:0]    REQ_READY;
  logic                ADD_DVI;
  logic [15:0]         ADD_A;
  logic [15:0]         ADD_B;
  logic [15:0]         ADD_DO;
  logic [5:0]          ADD_DO_TYPE;
  logic [N_REQ-1:0]    RSP_VALID;
  logic [15:0]         RSP_DATA;
  logic [5:0]          RSP_TYPE;
  logic                IDLE;
`ifdef FP16_ARB_STAT_EN
  logic                STAT_CLR;
  logic [16*N_REQ-1:0] STAT_EXC;
`endif

  int n_cmp;
  int n_fail;
  int n_rsp;

  fp16_add_arbiter #(
    .N_REQ(N_REQ), .ADD_LAT(ADD_LAT), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN),
    .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_READY(REQ_READY),
    .ADD_DVI(ADD_DVI), .ADD_A(ADD_A), .ADD_B(ADD_B),
    .ADD_DO(ADD_DO), .ADD_DO_TYPE(ADD_DO_TYPE),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_TYPE(RSP_TYPE),
`ifdef FP16_ARB_STAT_EN
    .STAT_CLR(STAT_CLR), .STAT_EXC(STAT_EXC),
`endif
    .IDLE(IDLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Mock adder: not real fp16 arithmetic, just distinctive and predictable results.
  // Inputs captured on the edge after DVI rises, result out ADD_LAT edges later; never reset.
  function automatic logic [15:0] mock_do(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h7C00 || b == 16'h7C00) return 16'h7C00;
    if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
    return a ^ b;
  endfunction

  function automatic logic [5:0] mock_type(input logic [15:0] d);
    if (d[14:10] == 5'h1F) return (d[9:0] != 10'd0) ? 6'b000001 : 6'b000100;
    if (d[14:0] == 15'd0)  return 6'b001000;
    if (d[14:10] == 5'd0)  return 6'b010000;
    return 6'b100000;
  endfunction

  logic [15:0] pa [0:ADD_LAT];
  logic [15:0] pb [0:ADD_LAT];

  always @(posedge CLK) begin
    pa[0] <= ADD_A;
    pb[0] <= ADD_B;
    for (int k = 1; k <= ADD_LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end

  assign ADD_DO      = mock_do(pa[ADD_LAT], pb[ADD_LAT]);
  assign ADD_DO_TYPE = mock_type(ADD_DO);

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, REQ_READY, 4'b0000);
    check({tag, "_dvi"},   ADD_DVI, 1'b0);
    check({tag, "_add_a"}, ADD_A, 16'h0000);
    check({tag, "_add_b"}, ADD_B, 16'h0000);
    check({tag, "_rsp_v"}, RSP_VALID, 4'b0000);
    check({tag, "_rsp_d"}, RSP_DATA, 16'h0000);
    check({tag, "_rsp_t"}, RSP_TYPE, 6'b000000);
    check({tag, "_idle"},  IDLE, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    n_rsp     = 0;
    RSTn      = 1'b1;
    EN        = 1'b0;
    REQ_VALID = '0;
`ifdef FP16_ARB_STAT_EN
    STAT_CLR  = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      REQ_A[16*i +: 16] = 16'h1000 + 16'(i);
      REQ_B[16*i +: 16] = 16'h0100;
    end

    // Reset values while RSTn is low and again right after release.
    #2 RSTn = 1'b0;
    #1 check_reset_values("rst");
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    #1 check_reset_values("rst_rel");

    // All requesters valid: grants rotate 0,1,2,3,... and each result lands 5 edges after its handshake.
    EN = 1'b1;
    for (int c = 0; c < 14; c++) begin
      REQ_VALID = (c < 8) ? 4'hF : 4'h0;
      #1 check("rr_ready", REQ_READY, (c < 8) ? oh(c % 4) : 4'b0000);
      tick();
      check("rr_dvi", ADD_DVI, c < 8);
      if (c < 8) check("rr_add_a", ADD_A, 16'h1000 + c % 4);
      if (c >= 5 && c < 13) begin
        check("rr_rsp_valid", RSP_VALID, oh((c - 5) % 4));
        check("rr_rsp_data", RSP_DATA, 16'h1100 + (c - 5) % 4);
      end else begin
        check("rr_rsp_idle", RSP_VALID, 4'b0000);
      end
      check("rr_idle", IDLE, c >= 13);
    end

    // Requester 1 alone: 1.0 + 1.0 comes back as 2.0, normal class.
    REQ_A[16 +: 16] = 16'h3C00;
    REQ_B[16 +: 16] = 16'h3C00;
    REQ_VALID = 4'b0010;
    #1 check("one_ready", REQ_READY, 4'b0010);
    tick();
    check("one_dvi", ADD_DVI, 1'b1);
    check("one_add_a", ADD_A, 16'h3C00);
    check("one_add_b", ADD_B, 16'h3C00);
    REQ_VALID = 4'b0000;
    for (int c = 1; c < 5; c++) begin
      tick();
      check("one_rsp_early", RSP_VALID, 4'b0000);
    end
    tick();
    check("one_rsp_valid", RSP_VALID, 4'b0010);
    check("one_rsp_data", RSP_DATA, 16'h4000);
    check("one_rsp_type", RSP_TYPE, 6'b100000);
    tick();
    check("one_rsp_drop", RSP_VALID, 4'b0000);
    check("one_idle", IDLE, 1'b1);
    REQ_A[16 +: 16] = 16'h1001;
    REQ_B[16 +: 16] = 16'h0100;

    // Requester 2 streams: four issues, blocked at MAX_OUTST, reopens the cycle after the first response.
    for (int c = 0; c < 15; c++) begin
      REQ_VALID = (c < 8) ? 4'b0100 : 4'b0000;
      #1 check("max_ready", REQ_READY, (c < 4 || c == 7) ? 4'b0100 : 4'b0000);
      tick();
      if (RSP_VALID == 4'b0100) n_rsp++;
    end
    check("max_rsp_count", n_rsp, 5);
    check("max_idle", IDLE, 1'b1);

    // Three ops in flight, then EN=0: nothing new issues, results drain, ptr is kept.
    REQ_VALID = 4'hF;
    #1 check("en_ready0", REQ_READY, 4'b1000);
    tick();
    #1 check("en_ready1", REQ_READY, 4'b0001);
    tick();
    #1 check("en_ready2", REQ_READY, 4'b0010);
    tick();
    EN = 1'b0;
    #1 check("en_off_ready", REQ_READY, 4'b0000);
    for (int c = 3; c < 9; c++) begin
      tick();
      check("en_off_dvi", ADD_DVI, 1'b0);
      case (c)
        5: begin
          check("en_rsp_v", RSP_VALID, 4'b1000);
          check("en_rsp_d", RSP_DATA, 16'h1103);
        end
        6: begin
          check("en_rsp_v", RSP_VALID, 4'b0001);
          check("en_rsp_d", RSP_DATA, 16'h1100);
        end
        7: begin
          check("en_rsp_v", RSP_VALID, 4'b0010);
          check("en_rsp_d", RSP_DATA, 16'h1101);
        end
        default: check("en_rsp_none", RSP_VALID, 4'b0000);
      endcase
      check("en_idle", IDLE, c >= 8);
    end
    EN = 1'b1;
    #1 check("en_resume_ready", REQ_READY, 4'b0100);

    // Reset with ops in flight: outputs drop at once and the stale results never appear.
    tick();
    check("rst_mid_add_a", ADD_A, 16'h1002);
    #1 check("rst_mid_ready", REQ_READY, 4'b1000);
    tick();
    REQ_VALID = 4'h0;
    tick();
    REQ_VALID = 4'hF;
    RSTn = 1'b0;
    #1 check_reset_values("rst_mid");
    REQ_VALID = 4'h0;
    tick();
    tick();
    RSTn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("rst_no_stale_rsp", RSP_VALID, 4'b0000);
    end

`ifdef FP16_ARB_STAT_EN
    // Requester 0: two infinite results and one normal one -> exception count 2, then cleared.
    check("stat_start", STAT_EXC, 64'd0);
    REQ_A[15:0] = 16'h7C00;
    REQ_B[15:0] = 16'h3C00;
    REQ_VALID   = 4'b0001;
    #1 check("stat_ready0", REQ_READY, 4'b0001);
    tick();
    #1 check("stat_ready1", REQ_READY, 4'b0001);
    tick();
    REQ_A[15:0] = 16'h3C00;
    tick();
    REQ_VALID = 4'b0000;
    tick();
    tick();
    tick();
    check("stat_rsp_v", RSP_VALID, 4'b0001);
    check("stat_rsp_d", RSP_DATA, 16'h7C00);
    check("stat_rsp_t", RSP_TYPE, 6'b000100);
    repeat (4) tick();
    check("stat_count", STAT_EXC, 64'd2);
    STAT_CLR = 1'b1;
    tick();
    STAT_CLR = 1'b0;
    check("stat_clear", STAT_EXC, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
